iter_barrel_shifter: RTL and testbench
======================================

ITER_BARREL_SHIFTER -- requirements
Module: iter_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits; legal values are powers of 2 from 4 to 64.
REQ-002 SHALL have derived localparam SHW = log2(WIDTH), default 4, shift-amount width and stage count.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port data_in, input, WIDTH, operand.
REQ-006 SHALL have port shamt, input, SHW, shift/rotate amount.
REQ-007 SHALL have port dir, input, 1; 0 = left, 1 = right.
REQ-008 SHALL have port rotate, input, 1; 1 = rotate, 0 = shift.
REQ-009 SHALL have port arith, input, 1; 1 = sign-fill on right shift.
REQ-010 SHALL have port in_valid, input, 1, request strobe.
REQ-011 SHALL have port in_ready, output, 1, engine can accept a request.
REQ-012 SHALL have port data_out, output, WIDTH, result.
REQ-013 SHALL have port out_valid, output, 1, result available.
REQ-014 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-017 SHALL drive in_ready = 1 only in IDLE; in_valid outside IDLE is ignored.
REQ-018 On in_valid && in_ready at edge N, SHALL capture data_in, shamt, dir, rotate and arith, clear stage counter to 0, and enter SHIFT.
REQ-019 In SHIFT, at each edge, for stage k (0..SHW-1) SHALL shift/rotate the working register by 2^k positions if captured shamt[k] = 1, else hold it; then increment k.
REQ-020 After stage SHW-1 is applied (edge N+SHW), SHALL enter DONE; out_valid is high from that edge: fixed latency of SHW cycles, independent of shamt, including shamt = 0.
REQ-021 Left shift SHALL zero-fill the LSBs; right shift with arith=0 SHALL zero-fill the MSBs; right shift with arith=1 SHALL replicate the captured bit WIDTH-1.
REQ-022 When rotate=1, SHALL rotate with bits wrapping around, and arith SHALL be ignored.
REQ-023 When dir=0 and rotate=0, arith SHALL be ignored.
REQ-024 In DONE, SHALL hold data_out and out_valid stable while out_ready=0, for an unbounded number of cycles.
REQ-025 In DONE with out_ready=1, SHALL return to IDLE at that edge, with out_valid low from that edge.
REQ-026 A new request SHALL be accepted no earlier than the cycle after the DONE-to-IDLE transition; throughput is at most one operation per SHW+2 cycles.
REQ-027 data_out SHALL retain the last result after returning to IDLE, until the next DONE updates it.
REQ-028 Input changes during SHIFT or DONE SHALL NOT affect the operation in flight.

Reset
REQ-029 When rst=1 at an edge, SHALL set state to IDLE, stage counter to 0, data_out to 0, out_valid to 0, and busy to 0; in_ready is 1 in the cycle after reset.
REQ-030 Reset SHALL take priority over in_valid and out_ready.
REQ-031 Reset asserted in SHIFT or DONE SHALL discard the operation in flight, with no out_valid pulse for it.

Verification (WIDTH=16)
REQ-032 Left shift: data_in=0x00F1, shamt=4, dir=0, rotate=0 -> out_valid exactly 4 cycles after the accept edge, data_out=0x0F10.
REQ-033 Right shifts on data_in=0x8000, shamt=3: arith=1 -> 0xF000; arith=0 -> 0x1000; dir=0, rotate=0, arith=1 -> 0x0000 (arith ignored).
REQ-034 Rotates: data_in=0x8001, shamt=1, dir=0, rotate=1 -> 0x0003; data_in=0x0001, shamt=15, dir=1, rotate=1 -> 0x0002; data_in=0x1234, shamt=0 -> 0x1234 after 4 cycles.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE and pulse in_valid with new data -> data_out and out_valid stable, in_ready=0, new request not taken; then out_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-operation: assert rst during SHIFT stage 2 -> next cycle busy=0, out_valid=0, data_out=0x0000, in_ready=1, and no result is ever emitted for the aborted request.
REQ-037 Back-to-back: two requests, each accepted the cycle after the previous DONE exit, with out_ready tied 1 -> results correct, accept edges 6 cycles apart.

Source files
------------

// File: rtl/iter_barrel_shifter.sv
// iter_barrel_shifter: shift/rotate engine applying one power-of-two stage per clock,
// giving a fixed latency of log2(WIDTH) cycles regardless of shift amount.
module iter_barrel_shifter #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic             rotate,
    input  logic             arith,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [SHW:0] WL = (SHW+1)'(WIDTH);
    state_t         state;
    logic [SHW-1:0] k, sh;
    logic [WIDTH-1:0] work, nxt, fill;
    logic [SHW:0]   amt;
    logic           c_dir, c_rot, sign_fill;
    // sign_fill folds arith, direction, rotate and the captured MSB into one flag
    always_comb begin
        amt  = sh[k] ? ((SHW+1)'(1) << k) : '0;
        fill = sign_fill ? ~({WIDTH{1'b1}} >> amt) : '0;
        nxt  = c_rot ? (c_dir ? (work >> amt) | (work << (WL - amt))
                              : (work << amt) | (work >> (WL - amt)))
                     : (c_dir ? (work >> amt) | fill : work << amt);
    end
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work      <= data_in;
                    sh        <= shamt;
                    c_dir     <= dir;
                    c_rot     <= rotate;
                    sign_fill <= arith & dir & ~rotate & data_in[WIDTH-1];
                    k         <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    work <= nxt;
                    k    <= k + 1'b1;
                    if (k == (SHW)'(SHW-1)) begin
                        state     <= DONE;
                        data_out  <= nxt;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_barrel_shifter.sv
// tb_iter_barrel_shifter: directed vector table plus backpressure, reset-abort and
// back-to-back sequences for the 16-bit configuration.
module tb_iter_barrel_shifter;
    logic        clk = 0;
    logic        rst = 1;
    logic [15:0] data_in = '0;
    logic [3:0]  shamt = '0;
    logic        dir = 0, rotate = 0, arith = 0, in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid, busy;
    logic [15:0] data_out;
    int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, lat = 0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  s;
        logic        dr, ro, ar;
        logic [15:0] e;
    } vec_t;
    vec_t vec [12];

    iter_barrel_shifter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .shamt(shamt), .dir(dir),
        .rotate(rotate), .arith(arith), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Issues a request at the next negedge, scrambles inputs while in flight, and
    // leaves the bench at the first negedge where out_valid is seen (or timeout).
    task automatic start_op(input vec_t v, input string name);
        @(negedge clk);
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        data_in = v.d; shamt = v.s; dir = v.dr; rotate = v.ro; arith = v.ar;
        in_valid = 1;
        @(negedge clk);
        acc_cyc = cyc;
        in_valid = 0;
        data_in = ~v.d; shamt = ~v.s; dir = ~v.dr; rotate = ~v.ro; arith = ~v.ar;
        lat = 0;
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check({name, " latency"}, lat, 4);
        check({name, " data"}, {16'd0, data_out}, {16'd0, v.e});
    endtask

    initial begin
        vec[0]  = '{16'h00F1, 4'd4,  1'b0, 1'b0, 1'b0, 16'h0F10};
        vec[1]  = '{16'h8000, 4'd3,  1'b1, 1'b0, 1'b1, 16'hF000};
        vec[2]  = '{16'h8000, 4'd3,  1'b1, 1'b0, 1'b0, 16'h1000};
        vec[3]  = '{16'h8000, 4'd3,  1'b0, 1'b0, 1'b1, 16'h0000};
        vec[4]  = '{16'h8001, 4'd1,  1'b0, 1'b1, 1'b0, 16'h0003};
        vec[5]  = '{16'h0001, 4'd15, 1'b1, 1'b1, 1'b0, 16'h0002};
        vec[6]  = '{16'h1234, 4'd0,  1'b0, 1'b0, 1'b0, 16'h1234};
        vec[7]  = '{16'h8000, 4'd3,  1'b1, 1'b1, 1'b1, 16'h1000};
        vec[8]  = '{16'h8421, 4'd15, 1'b1, 1'b0, 1'b1, 16'hFFFF};
        vec[9]  = '{16'h7FFF, 4'd15, 1'b1, 1'b0, 1'b1, 16'h0000};
        vec[10] = '{16'hF0F0, 4'd4,  1'b0, 1'b1, 1'b0, 16'h0F0F};
        vec[11] = '{16'h0003, 4'd15, 1'b0, 1'b0, 1'b0, 16'h8000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset data_out", {16'd0, data_out}, 32'd0);
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            start_op(vec[i], $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d exit", i), {30'd0, out_valid, busy}, 32'd0);
            check($sformatf("vec%0d retain", i), {16'd0, data_out}, {16'd0, vec[i].e});
        end

        // Backpressure: result must hold while out_ready is low
        out_ready = 0;
        start_op('{16'h00F1, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0F10}, "bp");
        for (int i = 0; i < 10; i++) begin
            data_in = 16'hAAAA; shamt = 4'd1; in_valid = i[0];
            @(negedge clk);
            check("bp hold", {14'd0, out_valid, in_ready, data_out}, {14'd0, 2'b10, 16'h0F10});
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        check("bp exit", {14'd0, out_valid, busy, data_out}, {14'd0, 2'b00, 16'h0F10});
        check("bp idle", {31'd0, in_ready}, 32'd1);

        // Reset while stage 2 is pending aborts the operation
        @(negedge clk);
        data_in = 16'h00FF; shamt = 4'd5; dir = 0; rotate = 0; arith = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort state", {13'd0, busy, out_valid, in_ready, data_out}, {13'd0, 3'b001, 16'h0000});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort no result", {31'd0, out_valid}, 32'd0);
        end

        // Back-to-back requests with out_ready tied high
        begin
            int first;
            start_op('{16'h0001, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0004}, "b2b0");
            first = acc_cyc;
            start_op('{16'hC000, 4'd2, 1'b1, 1'b0, 1'b1, 16'hF000}, "b2b1");
            check("b2b spacing", acc_cyc - first, 6);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
